switch_input_debounce: RTL and testbench

//   Input-side conditioning for the 8 board slide switches that feed the LED output path.
//   - Synchronises each raw switch into the clk domain and debounces it.
//   - Publishes a clean level per switch, plus one-cycle rise/fall pulses per switch.
//   - Sits between the board pins and any consumer: LED driver, mux select, counters.

---
 rtl/switch_input_debounce.sv | 103 ++++++++++
 tb/tb_switch_input_debounce.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_debounce.sv
// Two-flop synchroniser plus per-channel debounce for the board slide switches.
// Publishes clean levels and one-cycle rise/fall pulses once the power-up state is captured.
module switch_input_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic             ready
);

  localparam int INIT_W = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]            s1_q, s2_q;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic                        changed_q, changed_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [INIT_W-1:0]           init_cnt_q, init_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      changed_q  <= '0;
      cnt_q      <= '0;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      s1_q       <= sw_raw;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      changed_q  <= changed_d;
      cnt_q      <= cnt_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_cnt_q == INIT_LAST) begin
      state_d = ST_RUN;
    end
  end

  // INIT tracks the synchronised pins directly so the power-up positions never pulse.
  always_comb begin
    stable_d   = stable_q;
    rise_d     = '0;
    fall_d     = '0;
    cnt_d      = cnt_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      stable_d = s2_q;
      cnt_d    = '0;
      if (init_cnt_q != INIT_LAST) begin
        init_cnt_d = init_cnt_q + INIT_W'(1);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else begin
          stable_d[i] = s2_q[i];
          cnt_d[i]    = '0;
          rise_d[i]   = s2_q[i];
          fall_d[i]   = ~s2_q[i];
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_comb begin
    ready      = (state_q == ST_RUN);
    sw_stable  = stable_q;
    sw_rise    = rise_q;
    sw_fall    = fall_q;
    sw_changed = changed_q;
  end

endmodule

// File: tb/tb_switch_input_debounce.sv
// Scoreboard bench for switch_input_debounce with DEBOUNCE_CYCLES=4: directed vectors plus a
// model-driven random bounce soak, all checked by a monitor that pops per-cycle expectations.
module tb_switch_input_debounce;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] sw_raw = '0;
  logic [WIDTH-1:0] sw_stable, sw_rise, sw_fall;
  logic             sw_changed, ready;

  switch_input_debounce #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .sw_stable(sw_stable), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .sw_changed(sw_changed), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
    logic       rdy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    passed = 0;
  bit    soak_on = 1'b0;
  int    dut_pulses[WIDTH];
  int    model_acc[WIDTH];

  logic [7:0] m_s1, m_s2, m_stable, m_rise, m_fall;
  int         m_hold[WIDTH];
  int         m_init;
  bit         m_run;

  task automatic checkOutput(input string name, input logic [7:0] e_st, input logic [7:0] e_ri,
                             input logic [7:0] e_fa, input logic e_ch, input logic e_rd);
    checks++;
    if (sw_stable !== e_st || sw_rise !== e_ri || sw_fall !== e_fa ||
        sw_changed !== e_ch || ready !== e_rd) begin
      $display("[TB] FAIL %s cycle %0d: got stable=%h rise=%h fall=%h chg=%b rdy=%b, expected stable=%h rise=%h fall=%h chg=%b rdy=%b",
               name, cyc, sw_stable, sw_rise, sw_fall, sw_changed, ready, e_st, e_ri, e_fa, e_ch, e_rd);
    end else begin
      passed++;
    end
  endtask

  task automatic pushExp(input string name, input int at, input logic [7:0] st, input logic [7:0] ri,
                         input logic [7:0] fa, input logic ch, input logic rd);
    exp_t e;
    e.cyc = at; e.stable = st; e.rise = ri; e.fall = fa; e.chg = ch; e.rdy = rd;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic applyStimulus(input logic [7:0] raw, output int base);
    @(negedge clk);
    sw_raw = raw;
    base = cyc;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A clean change lands on the sixth edge after the negedge that drove it.
  task automatic pushChange(input string name, input int base, input logic [7:0] old_v,
                            input logic [7:0] new_v, input logic [7:0] ri, input logic [7:0] fa);
    for (int k = 1; k <= 8; k++) begin
      if (k < 6)       pushExp(name, base + k, old_v, 8'h00, 8'h00, 1'b0, 1'b1);
      else if (k == 6) pushExp(name, base + k, new_v, ri, fa, 1'b1, 1'b1);
      else             pushExp(name, base + k, new_v, 8'h00, 8'h00, 1'b0, 1'b1);
    end
  endtask

  task automatic pushInit(input string name, input int base, input logic [7:0] v);
    for (int k = 1; k <= 10; k++) begin
      pushExp(name, base + k, (k >= 3) ? v : 8'h00, 8'h00, 8'h00, 1'b0, (k >= 6));
    end
  endtask

  task automatic modelReset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
    m_init = 0; m_run = 1'b0;
    for (int b = 0; b < WIDTH; b++) m_hold[b] = 0;
  endtask

  // Advances the reference by one rising edge, given the pin value that edge samples.
  task automatic modelStep(input logic [7:0] raw);
    logic [7:0] old_s1, old_s2;
    old_s1 = m_s1; old_s2 = m_s2;
    m_s1 = raw; m_s2 = old_s1;
    m_rise = '0; m_fall = '0;
    if (!m_run) begin
      m_stable = old_s2;
      if (m_init == DEB + 1) m_run = 1'b1;
      else m_init++;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (old_s2[b] == m_stable[b]) begin
          m_hold[b] = 0;
        end else begin
          m_hold[b]++;
          if (m_hold[b] == DEB) begin
            m_stable[b] = old_s2[b];
            m_hold[b] = 0;
            if (old_s2[b]) m_rise[b] = 1'b1;
            else m_fall[b] = 1'b1;
            model_acc[b]++;
          end
        end
      end
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (soak_on) begin
        for (int b = 0; b < WIDTH; b++) if (sw_rise[b] | sw_fall[b]) dut_pulses[b]++;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          $display("[TB] FAIL %s: expectation for cycle %0d missed, now cycle %0d", nm, e.cyc, cyc);
        end else begin
          checkOutput(nm, e.stable, e.rise, e.fall, e.chg, e.rdy);
        end
      end
    end
  end

  initial begin : stimulus
    int base;
    int guard;
    logic [7:0] raw_v, mask;
    logic [7:0] bounce_seq [8];
    for (int b = 0; b < WIDTH; b++) begin
      dut_pulses[b] = 0;
      model_acc[b]  = 0;
    end

    rst_n  = 1'b0;
    sw_raw = 8'hA5;
    waitCycles(3);
    checkOutput("reset_state", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    pushInit("init_capture", base, 8'hA5);
    waitCycles(12);

    applyStimulus(8'h00, base);
    pushChange("fall_all", base, 8'hA5, 8'h00, 8'h00, 8'hA5);
    waitCycles(9);

    applyStimulus(8'h01, base);
    pushChange("rise_bit0", base, 8'h00, 8'h01, 8'h01, 8'h00);
    waitCycles(9);

    bounce_seq = '{8'h09, 8'h09, 8'h09, 8'h01, 8'h09, 8'h09, 8'h09, 8'h01};
    applyStimulus(bounce_seq[0], base);
    for (int k = 1; k <= 14; k++) pushExp("bounce_reject", base + k, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      sw_raw = bounce_seq[i];
    end
    waitCycles(8);

    applyStimulus(8'h0F, base);
    pushChange("settle_0F", base, 8'h01, 8'h0F, 8'h0E, 8'h00);
    waitCycles(9);

    applyStimulus(8'hF0, base);
    pushChange("simultaneous", base, 8'h0F, 8'hF0, 8'hF0, 8'h0F);
    waitCycles(9);

    applyStimulus(8'hF1, base);
    waitCycles(2);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;
    base  = cyc;
    pushInit("reinit_capture", base, 8'hF1);
    waitCycles(12);

    @(negedge clk);
    rst_n  = 1'b0;
    sw_raw = 8'h00;
    modelReset();
    waitCycles(2);
    raw_v   = 8'h00;
    soak_on = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      if ((i % 10000) < 9992) begin
        mask = '0;
        for (int b = 0; b < WIDTH; b++) mask[b] = ($urandom_range(5) == 0);
        raw_v = raw_v ^ mask;
      end
      sw_raw = raw_v;
      modelStep(raw_v);
      pushExp("soak", cyc + 1, m_stable, m_rise, m_fall, |(m_rise | m_fall), m_run);
    end
    waitCycles(3);
    soak_on = 1'b0;

    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations never consumed, required 0", exp_q.size());
    end

    for (int b = 0; b < WIDTH; b++) begin
      checks++;
      if (dut_pulses[b] == model_acc[b]) begin
        passed++;
      end else begin
        $display("[TB] FAIL pulse_count bit %0d: got %0d pulses, expected %0d", b, dut_pulses[b], model_acc[b]);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
